vec_change_capture: RTL and testbench



---
 rtl/vec_capture_pkg.sv | 24 ++
 rtl/vec_change_capture_if.sv | 14 +
 rtl/vec_capture_fifo.sv | 54 +++++
 rtl/vec_change_capture.sv | 94 +++++++++
 tb/tb_vec_change_capture.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/vec_capture_pkg.sv
// Shared types and constants for the vector change-capture stage.
// Holds the FSM state encoding, the drop-counter limits and the default-width entry record.
package vec_capture_pkg;

  typedef enum logic {
    UNPRIMED = 1'b0,
    ARMED    = 1'b1
  } state_t;

  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

  localparam int VEC_W = 32;
  localparam int TS_W  = 16;

  // Entry record at default widths, for consumers that decode the trace stream.
  typedef struct packed {
    logic [VEC_W-1:0] vec;
`ifdef VEC_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0]  ts;
`endif
  } entry_t;

endpackage

// File: rtl/vec_change_capture_if.sv
// Valid/ready drain port carrying the captured vector and its timestamp.
// The capture stage drives it as master; the trace consumer is the slave.
interface vec_change_capture_if #(
  parameter int WIDTH    = 32,
  parameter int TS_WIDTH = 16
);
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_vec;
  logic [TS_WIDTH-1:0] out_ts;

  modport master (output out_valid, output out_vec, output out_ts, input out_ready);
  modport slave  (input out_valid, input out_vec, input out_ts, output out_ready);
endinterface

// File: rtl/vec_capture_fifo.sv
// Synchronous FIFO with one-bit-wider pointers for full/empty; head data is visible the cycle after a push.
// Latency 1 cycle; push while full is ignored unless a pop happens in the same cycle.
module vec_capture_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wr_dat,
  output logic [DW-1:0]            rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level  = wr_ptr_q - rd_ptr_q;
  assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];

  // When full, the write slot equals the head slot; the head is read before the write lands.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && (!full || pop)) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_dat;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/vec_change_capture.sv
// Captures each change of vec_in (first sample always) into a FIFO; head valid one cycle after capture.
// Backpressure: full FIFO without a pop drops the change and bumps drop_cnt; VEC_CAPTURE_TIMESTAMP_EN adds ts.
module vec_change_capture
  import vec_capture_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int TS_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        vec_in,
  input  logic                    sample_en,
  vec_change_capture_if.master    out_if,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);
`ifdef VEC_CAPTURE_TIMESTAMP_EN
  localparam int EW = WIDTH + TS_WIDTH;
`else
  localparam int EW = WIDTH;
`endif

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        prev_q, prev_d;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;
  logic                    capture, push, pop, fifo_full, fifo_empty;
  logic [EW-1:0]           wr_dat, rd_dat;

  assign pop = out_if.out_valid && out_if.out_ready;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    drop_d  = drop_q;
    capture = sample_en && ((state_q == UNPRIMED) || (vec_in != prev_q));
    // prev follows every capture, so a dropped change is not re-reported later.
    if (capture) begin
      prev_d  = vec_in;
      state_d = ARMED;
      if (fifo_full && !pop && (drop_q != DROP_CNT_MAX)) drop_d = drop_q + 1'b1;
    end
    push = capture && (!fifo_full || pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNPRIMED;
      prev_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      drop_q  <= drop_d;
    end
  end

`ifdef VEC_CAPTURE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_q, ts_cnt_d;

  assign ts_cnt_d = ts_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) ts_cnt_q <= '0;
    else     ts_cnt_q <= ts_cnt_d;
  end

  assign wr_dat         = {vec_in, ts_cnt_q};
  assign out_if.out_vec = rd_dat[EW-1 -: WIDTH];
  assign out_if.out_ts  = rd_dat[TS_WIDTH-1:0];
`else
  assign wr_dat         = vec_in;
  assign out_if.out_vec = rd_dat;
  assign out_if.out_ts  = {TS_WIDTH{1'b0}};
`endif

  vec_capture_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wr_dat (wr_dat),
    .rd_dat (rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign out_if.out_valid = !fifo_empty;
  assign drop_cnt         = drop_q;
endmodule

// File: tb/tb_vec_change_capture.sv
// Randomised and directed bench for vec_change_capture against a queue-based reference model.
module tb_vec_change_capture;
  localparam int WIDTH    = 32;
  localparam int DEPTH    = 4;
  localparam int TS_WIDTH = 16;
`ifdef VEC_CAPTURE_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_en;
  logic [WIDTH-1:0]  vec_in;
  logic              out_ready;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [7:0]        drop_cnt;

  vec_change_capture_if #(.WIDTH(WIDTH), .TS_WIDTH(TS_WIDTH)) bus ();
  assign bus.out_ready = out_ready;

  vec_change_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .vec_in     (vec_in),
    .sample_en  (sample_en),
    .out_if     (bus),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, plus last-captured value and counters.
  logic [WIDTH+TS_WIDTH-1:0] mq[$];
  logic [WIDTH-1:0]          m_prev;
  bit                        m_primed;
  int                        m_drop;
  logic [TS_WIDTH-1:0]       m_ts;
  bit                        m_pop, m_cap, m_full;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_prev   = '0;
      m_primed = 1'b0;
      m_drop   = 0;
      m_ts     = '0;
    end else begin
      m_pop  = (mq.size() > 0) && out_ready;
      m_cap  = sample_en && (!m_primed || vec_in != m_prev);
      m_full = (mq.size() == DEPTH);
      if (m_pop) void'(mq.pop_front());
      if (m_cap) begin
        m_prev   = vec_in;
        m_primed = 1'b1;
        if (!m_full || m_pop) mq.push_back({vec_in, m_ts});
        else if (m_drop < 255) m_drop++;
      end
      m_ts = m_ts + 1'b1;
    end
    #1;
    chk("valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    chk("level", 64'(fifo_level), 64'(mq.size()));
    chk("drop",  64'(drop_cnt), 64'(m_drop));
    if (mq.size() > 0) begin
      chk("vec", 64'(bus.out_vec), 64'(mq[0][WIDTH+TS_WIDTH-1:TS_WIDTH]));
      chk("ts",  64'(bus.out_ts), TS_ON ? 64'(mq[0][TS_WIDTH-1:0]) : 64'd0);
    end
  end

  // Inputs change on the falling edge; outputs seen here reflect all earlier drives.
  task automatic drive(input logic r, input logic se, input logic [WIDTH-1:0] v, input logic rdy);
    @(negedge clk);
    rst       = r;
    sample_en = se;
    vec_in    = v;
    out_ready = rdy;
  endtask

  logic [WIDTH-1:0] six [6];
  logic [WIDTH-1:0] drain_exp [4];

  initial begin
    rst = 1'b1; sample_en = 1'b0; vec_in = '0; out_ready = 1'b0;
    six       = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
    drain_exp = '{32'h22, 32'h33, 32'h44, 32'h77};

    // Reset state and UNPRIMED baseline capture.
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_vec",   64'(bus.out_vec), 64'd0);
    chk("rst_ts",    64'(bus.out_ts), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_drop",  64'(drop_cnt), 64'd0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    chk("base_valid", 64'(bus.out_valid), 64'd1);
    chk("base_vec",   64'(bus.out_vec), 64'd0);
    chk("base_ts",    64'(bus.out_ts), TS_ON ? 64'd1 : 64'd0);
    drive(0, 1, 0, 0);
    chk("hold_level", 64'(fifo_level), 64'd1);
    drive(0, 0, 0, 1);
    chk("hold_level2", 64'(fifo_level), 64'd1);

    // Consecutive steps with the consumer always ready.
    drive(0, 1, 32'h1, 1);
    drive(0, 1, 32'h2, 1);
    drive(0, 1, 32'h4, 1);
    drive(0, 0, 0, 1);
    chk("step_level", 64'(fifo_level), 64'd1);
    chk("step_drop",  64'(drop_cnt), 64'd0);
    drive(0, 0, 0, 1);
    chk("step_empty", 64'(fifo_level), 64'd0);

    // Fill, overflow by two, repeat ignored, then full-with-pop.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, six[i], 0);
    drive(0, 1, six[5], 0);
    drive(0, 1, 32'h77, 1);
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_drop",  64'(drop_cnt), 64'd2);
    drive(0, 0, 0, 1);
    chk("fp_level", 64'(fifo_level), 64'd4);
    chk("fp_drop",  64'(drop_cnt), 64'd2);
    chk("drain0",   64'(bus.out_vec), 64'(drain_exp[0]));
    for (int i = 1; i < 4; i++) begin
      drive(0, 0, 0, 1);
      chk("drain", 64'(bus.out_vec), 64'(drain_exp[i]));
    end
    drive(0, 0, 0, 0);
    chk("drain_empty", 64'(fifo_level), 64'd0);

    // Saturate the drop counter.
    for (int i = 0; i < 304; i++) drive(0, 1, 32'h100 + i, 0);
    drive(0, 0, 0, 0);
    chk("sat_drop",  64'(drop_cnt), 64'd255);
    chk("sat_level", 64'(fifo_level), 64'd4);

    // Timestamp wrap: capture at ts=0xFFFF and at ts=0x0000.
    drive(0, 0, 0, 1);
    for (int g = 0; g < 70000 && m_ts != 16'hFFFE; g++) @(negedge clk);
    chk("ts_reach", 64'(m_ts), 64'hFFFE);
    drive(0, 1, 32'hA5A5_0001, 0);
    drive(0, 1, 32'hA5A5_0002, 0);
    drive(0, 0, 0, 1);
    chk("wrap_vec0", 64'(bus.out_vec), 64'hA5A5_0001);
    chk("wrap_ts0",  64'(bus.out_ts), TS_ON ? 64'hFFFF : 64'd0);
    drive(0, 0, 0, 1);
    chk("wrap_vec1", 64'(bus.out_vec), 64'hA5A5_0002);
    chk("wrap_ts1",  64'(bus.out_ts), 64'd0);

    // Random traffic with occasional resets; small value pool forces repeats.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1));
    end

    // Reset with three entries queued and a ready in the same cycle.
    drive(1, 0, 0, 0);
    drive(0, 1, 32'h1, 0);
    drive(0, 1, 32'h2, 0);
    drive(0, 1, 32'h3, 0);
    drive(1, 0, 0, 1);
    chk("pre_rst_level", 64'(fifo_level), 64'd3);
    drive(0, 1, 32'h3, 0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_level", 64'(fifo_level), 64'd0);
    chk("flush_drop",  64'(drop_cnt), 64'd0);
    drive(0, 0, 0, 0);
    chk("reprime_level", 64'(fifo_level), 64'd1);
    chk("reprime_vec",   64'(bus.out_vec), 64'd3);
    drive(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
